// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state codes and default widths.
package pc_seq_pkg;

  localparam int unsigned PC_W_DEF     = 16;
  localparam int unsigned RESET_PC_DEF = 0;
  localparam int unsigned CNT_W        = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/ret_addr_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry; a pop when empty is ignored.
module ret_addr_stack #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top_c,
  output logic         full_c,
  output logic         empty_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] sp_q, sp_d;
  logic [AW:0]   cnt_q, cnt_d;

  assign full_c  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_c = (cnt_q == '0);
  assign top_c   = mem_q[sp_q - AW'(1)];

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (push) begin
      sp_d = sp_q + AW'(1);
      if (!full_c) cnt_d = cnt_q + (AW+1)'(1);
    end else if (pop && !empty_c) begin
      sp_d  = sp_q - AW'(1);
      cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[sp_q] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch handshake, taken-branch redirect with flush bubbles, link value.
// Defining PC_SEQ_RAS_EN adds a return-address stack that supplies return targets.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter int unsigned RESET_PC  = RESET_PC_DEF,
  parameter int unsigned FLUSH_CYC = 1,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch,
  input  logic [PC_W-1:0] target,
  input  logic            abs_tgt,
  input  logic            is_call,
  input  logic            is_ret,
  input  logic            stall,
  input  logic            imem_ready,
  output logic [PC_W-1:0] pc,
  output logic            imem_req,
  output logic            flush,
  output logic [PC_W-1:0] ret_addr,
  output logic            ras_err
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  pc_q, pc_d, ret_q, ret_d;
  logic             req_q, req_d, flush_q, flush_d, err_q, err_d;
  logic             taken_c, call_c;
  logic [PC_W-1:0]  pc_inc_c, jump_tgt_c, redirect_c;

  assign taken_c    = (state_q == ST_FETCH) & branch & ~stall;
  assign call_c     = taken_c & is_call;
  assign pc_inc_c   = pc_q + PC_W'(1);
  assign jump_tgt_c = abs_tgt ? target : pc_q + target;

`ifdef PC_SEQ_RAS_EN
  logic            ret_c, pop_c, ras_full_c, ras_empty_c;
  logic [PC_W-1:0] ras_top_c;

  // Call wins when both kinds are flagged; an empty stack falls back to the supplied target.
  assign ret_c = taken_c & is_ret & ~is_call;
  assign pop_c = ret_c & ~ras_empty_c;

  ret_addr_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .push    (call_c),
    .pop     (pop_c),
    .din     (pc_inc_c),
    .top_c   (ras_top_c),
    .full_c  (ras_full_c),
    .empty_c (ras_empty_c)
  );

  assign redirect_c = pop_c ? ras_top_c : jump_tgt_c;
  assign err_d      = err_q | (call_c & ras_full_c) | (ret_c & ras_empty_c);
`else
  logic unused_c;
  assign unused_c   = is_ret | (RAS_DEPTH == 0);
  assign redirect_c = jump_tgt_c;
  assign err_d      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    ret_d   = ret_q;
    flush_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!stall) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (taken_c) begin
          pc_d    = redirect_c;
          flush_d = 1'b1;
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYC - 1);
          if (call_c) ret_d = pc_inc_c;
        end else if (imem_ready && !stall) begin
          pc_d = pc_inc_c;
        end
      end
      ST_FLUSH: begin
        if (!stall) begin
          if (cnt_q == '0) state_d = ST_FETCH;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_d = (state_d == ST_FETCH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pc_q    <= PC_W'(RESET_PC);
      ret_q   <= '0;
      req_q   <= 1'b0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
      req_q   <= req_d;
      flush_q <= flush_d;
      err_q   <= err_d;
    end
  end

  assign pc       = pc_q;
  assign imem_req = req_q;
  assign flush    = flush_q;
  assign ret_addr = ret_q;
  assign ras_err  = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model predicts each cycle's outputs into a queue
// that an independent monitor drains; directed scenarios plus a randomized run.
module tb_pc_sequencer;

  localparam int unsigned PC_W      = 16;
  localparam int unsigned FLUSH_CYC = 2;
  localparam int unsigned RAS_DEPTH = 8;
  localparam int          MASK      = 32'h0000_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch, abs_tgt, is_call, is_ret, stall, imem_ready;
  logic [15:0] target;
  logic [15:0] pc, ret_addr;
  logic        imem_req, flush, ras_err;

  pc_sequencer #(
    .PC_W      (PC_W),
    .RESET_PC  (0),
    .FLUSH_CYC (FLUSH_CYC),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .branch     (branch),
    .target     (target),
    .abs_tgt    (abs_tgt),
    .is_call    (is_call),
    .is_ret     (is_ret),
    .stall      (stall),
    .imem_ready (imem_ready),
    .pc         (pc),
    .imem_req   (imem_req),
    .flush      (flush),
    .ret_addr   (ret_addr),
    .ras_err    (ras_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic        req;
    logic        flush;
    logic [15:0] ret;
    logic        err;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   passed = 0;

  // Behavioural model: fetch position, remaining bubble cycles, link value, return stack.
  int   m_pc, m_ret, m_bub;
  bit   m_idle, m_err, m_flush;
  int   m_stack[$];

`ifdef PC_SEQ_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_pc = 0; m_ret = 0; m_bub = 0; m_idle = 1'b1; m_err = 1'b0; m_flush = 1'b0;
    m_stack.delete();
  endfunction

  // Called just after a falling edge: drive, predict the state after the next rising edge, advance.
  task automatic step(input bit br, input logic [15:0] tgt, input bit abs_i, input bit call,
                      input bit ret, input bit stl, input bit rdy);
    int   nxt;
    exp_t e;
    branch = br; target = tgt; abs_tgt = abs_i; is_call = call; is_ret = ret;
    stall = stl; imem_ready = rdy;
    m_flush = 1'b0;
    if (!stl) begin
      if (m_idle) m_idle = 1'b0;
      else if (m_bub > 0) m_bub--;
      else if (br) begin
        nxt = abs_i ? int'(tgt) : (m_pc + int'(tgt)) & MASK;
        if (call) begin
          m_ret = (m_pc + 1) & MASK;
          if (RAS_ON) begin
            if (m_stack.size() == RAS_DEPTH) begin
              void'(m_stack.pop_front());
              m_err = 1'b1;
            end
            m_stack.push_back(m_ret);
          end
        end else if (ret && RAS_ON) begin
          if (m_stack.size() == 0) m_err = 1'b1;
          else nxt = m_stack.pop_back();
        end
        m_pc = nxt; m_bub = FLUSH_CYC; m_flush = 1'b1;
      end else if (rdy) m_pc = (m_pc + 1) & MASK;
    end
    e.pc = 16'(m_pc); e.req = !m_idle && (m_bub == 0); e.flush = m_flush;
    e.ret = 16'(m_ret); e.err = m_err;
    expq.push_back(e);
    @(negedge clk);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic jump_abs(input logic [15:0] t);
    step(1'b1, t, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    nop(FLUSH_CYC);
  endtask

  // Monitor: compares every cycle the model predicted.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && expq.size() > 0) begin
        e = expq.pop_front();
        chk("mon_pc",    32'(pc),       32'(e.pc));
        chk("mon_req",   32'(imem_req), 32'(e.req));
        chk("mon_flush", 32'(flush),    32'(e.flush));
        chk("mon_ret",   32'(ret_addr), 32'(e.ret));
        chk("mon_err",   32'(ras_err),  32'(e.err));
      end
    end
  end

  initial begin
    int t1 [6] = '{0, 0, 1, 2, 3, 4};
    int ret_exp;
    rst = 1'b1; branch = 0; target = '0; abs_tgt = 0; is_call = 0; is_ret = 0;
    stall = 0; imem_ready = 1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_ret", 32'(ret_addr), 0);
    chk("rst_err", 32'(ras_err), 0);
    rst = 1'b0;

    // Sequential fetch out of reset.
    for (int i = 0; i < 6; i++) begin
      chk("t1_pc", 32'(pc), 32'(t1[i]));
      chk("t1_flush", 32'(flush), 0);
      nop(1);
    end

    // Negative relative branch.
    jump_abs(16'h0010);
    step(1'b1, 16'hFFFC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_flush", 32'(flush), 1);
    chk("t2_pc", 32'(pc), 32'h000C);
    nop(1);
    chk("t2_flush_drop", 32'(flush), 0);
    nop(FLUSH_CYC - 1);
    chk("t2_req", 32'(imem_req), 1);
    chk("t2_pc_bus", 32'(pc), 32'h000C);

    // Memory back-pressure.
    jump_abs(16'h0005);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t3_pc_hold", 32'(pc), 32'h0005);
      chk("t3_req_hold", 32'(imem_req), 1);
    end
    nop(1);
    chk("t3_pc_inc", 32'(pc), 32'h0006);

    // Call then return.
    jump_abs(16'h0020);
    step(1'b1, 16'h0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t4_ret_addr", 32'(ret_addr), 32'h0021);
    chk("t4_pc_call", 32'(pc), 32'h0100);
    nop(FLUSH_CYC);
    step(1'b1, 16'h0555, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    ret_exp = RAS_ON ? 32'h0021 : 32'h0555;
    chk("t4_pc_ret", 32'(pc), 32'(ret_exp));
    nop(FLUSH_CYC);

    // Stack overflow then unwinding; the model checks each popped target.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 16'(16'h1000 + 16'(i * 16)), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      nop(FLUSH_CYC);
      if (i == 7) chk("t5_err_full", 32'(ras_err), 0);
    end
    chk("t5_err_ovf", 32'(ras_err), 32'(RAS_ON));
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 16'h0777, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      nop(FLUSH_CYC);
    end

    // Reset while flushing under stall.
    step(1'b1, 16'h0200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    stall = 1'b1;
    rst = 1'b1;
    #1;
    chk("t6_pc", 32'(pc), 0);
    chk("t6_flush", 32'(flush), 0);
    chk("t6_req", 32'(imem_req), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    chk("t6_idle_req", 32'(imem_req), 0);
    nop(1);
    chk("t6_fetch_req", 32'(imem_req), 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 20, 16'($urandom), 1'($urandom), $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 70);
    end

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(expq.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
